// File: rtl/decode_stage_param.sv
// RV32 ID stage with 2R/1W register file and ID/EX pipeline register.
// Supports EX stall (hold), bubble injection (flush) and illegal-instruction tagging.
module decode_stage_param #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter bit          RF_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validD,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] pcD,
  input  logic [XLEN-1:0] pc4D,
  input  logic            regwriteW,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] resultW,
  input  logic            holdE,
  input  logic            flushE,
  output logic            validE,
  output logic            regwriteE,
  output logic            memrwE,
  output logic            branchE,
  output logic            jumpE,
  output logic            aselE,
  output logic            bselE,
  output logic [1:0]      wbselE,
  output logic [3:0]      aluselE,
  output logic [2:0]      funct3E,
  output logic [4:0]      rdE,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E,
  output logic [XLEN-1:0] rd1E,
  output logic [XLEN-1:0] rd2E,
  output logic [XLEN-1:0] imm_exE,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] pc4E,
  output logic            illegalE
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wbsel_e;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memrw;
    logic            branch;
    logic            jump;
    logic            asel;
    logic            bsel;
    logic [1:0]      wbsel;
    logic [3:0]      alusel;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            illegal;
  } ex_t;

  logic [XLEN-1:0] r_rf [NREG];
  ex_t             r_ex;
  ex_t             w_ex;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_rd1, w_rd2;
  logic [31:0]     w_imm32;
  logic            w_legal, w_use_rd, w_use_rs1, w_use_rs2;
  logic            w_rw, w_mw, w_br, w_j, w_asel, w_bsel;
  wbsel_e          w_wbsel;
  alu_e            w_alusel;

  assign w_opcode = instrD[6:0];
  assign w_rd     = instrD[11:7];
  assign w_funct3 = instrD[14:12];
  assign w_rs1    = instrD[19:15];
  assign w_rs2    = instrD[24:20];
  assign w_funct7 = instrD[31:25];

  function automatic logic in_range(input logic [4:0] a);
    return 32'(a) < NREG;
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  function automatic alu_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (a != '0 && in_range(a)) v = r_rf[a[AW-1:0]];
    if (RF_BYPASS && regwriteW && rdW != '0 && in_range(rdW) && rdW == a) v = resultW;
    return v;
  endfunction

  assign w_rd1 = rf_read(w_rs1);
  assign w_rd2 = rf_read(w_rs2);

  always_comb begin
    w_rw      = 1'b0;
    w_mw      = 1'b0;
    w_br      = 1'b0;
    w_j       = 1'b0;
    w_asel    = 1'b0;
    w_bsel    = 1'b0;
    w_wbsel   = WB_MEM;
    w_alusel  = ALU_ADD;
    w_imm32   = '0;
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        {w_use_rd, w_use_rs1, w_use_rs2} = 3'b111;
        w_rw     = 1'b1;
        w_wbsel  = WB_ALU;
        w_alusel = alu_op(w_funct3, w_funct7[5]);
        w_legal  = (w_funct7 == 7'h00) ||
                   (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
      end
      OP_IMM: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_rw     = 1'b1;
        w_bsel   = 1'b1;
        w_wbsel  = WB_ALU;
        w_alusel = alu_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_imm32 = {27'd0, instrD[24:20]};
          w_legal = (w_funct7 == 7'h00) || (w_funct3 == 3'b101 && w_funct7 == 7'h20);
        end else begin
          w_imm32 = {{20{instrD[31]}}, instrD[31:20]};
          w_legal = 1'b1;
        end
      end
      OP_LOAD: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_rw    = 1'b1;
        w_bsel  = 1'b1;
        w_imm32 = {{20{instrD[31]}}, instrD[31:20]};
        w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
      end
      OP_STORE: begin
        {w_use_rs1, w_use_rs2} = 2'b11;
        w_mw    = 1'b1;
        w_bsel  = 1'b1;
        w_imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
        w_legal = (w_funct3 < 3'b011);
      end
      OP_BRANCH: begin
        {w_use_rs1, w_use_rs2} = 2'b11;
        w_br     = 1'b1;
        w_alusel = ALU_SUB;
        w_imm32  = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
        w_legal  = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
      end
      OP_JAL: begin
        w_use_rd = 1'b1;
        w_rw     = 1'b1;
        w_j      = 1'b1;
        w_asel   = 1'b1;
        w_bsel   = 1'b1;
        w_wbsel  = WB_PC4;
        w_imm32  = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
        w_legal  = 1'b1;
      end
      OP_JALR: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_rw    = 1'b1;
        w_j     = 1'b1;
        w_bsel  = 1'b1;
        w_wbsel = WB_PC4;
        w_imm32 = {{20{instrD[31]}}, instrD[31:20]};
        w_legal = (w_funct3 == 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        w_use_rd = 1'b1;
        w_rw     = 1'b1;
        w_bsel   = 1'b1;
        w_asel   = (w_opcode == OP_AUIPC);
        w_alusel = (w_opcode == OP_LUI) ? ALU_PASSB : ALU_ADD;
        w_wbsel  = WB_ALU;
        w_imm32  = {instrD[31:12], 12'd0};
        w_legal  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    // Register indices beyond the implemented file (RV32E) make the instruction illegal.
    if ((w_use_rd && !in_range(w_rd)) || (w_use_rs1 && !in_range(w_rs1)) ||
        (w_use_rs2 && !in_range(w_rs2)))
      w_legal = 1'b0;
  end

  always_comb begin
    w_ex = '0;
    if (validD) begin
      w_ex.valid   = 1'b1;
      w_ex.funct3  = w_funct3;
      w_ex.rd      = w_rd;
      w_ex.rs1     = w_rs1;
      w_ex.rs2     = w_rs2;
      w_ex.rd1     = w_rd1;
      w_ex.rd2     = w_rd2;
      w_ex.pc      = pcD;
      w_ex.pc4     = pc4D;
      w_ex.illegal = !w_legal;
      if (w_legal) begin
        w_ex.regwrite = w_rw;
        w_ex.memrw    = w_mw;
        w_ex.branch   = w_br;
        w_ex.jump     = w_j;
        w_ex.asel     = w_asel;
        w_ex.bsel     = w_bsel;
        w_ex.wbsel    = w_wbsel;
        w_ex.alusel   = w_alusel;
        w_ex.imm      = sext(w_imm32);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (regwriteW && rdW != '0 && in_range(rdW)) begin
      r_rf[rdW[AW-1:0]] <= resultW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ex <= '0;
    else if (flushE)  r_ex <= '0;
    else if (!holdE)  r_ex <= w_ex;
  end

  assign validE    = r_ex.valid;
  assign regwriteE = r_ex.regwrite;
  assign memrwE    = r_ex.memrw;
  assign branchE   = r_ex.branch;
  assign jumpE     = r_ex.jump;
  assign aselE     = r_ex.asel;
  assign bselE     = r_ex.bsel;
  assign wbselE    = r_ex.wbsel;
  assign aluselE   = r_ex.alusel;
  assign funct3E   = r_ex.funct3;
  assign rdE       = r_ex.rd;
  assign rs1E      = r_ex.rs1;
  assign rs2E      = r_ex.rs2;
  assign rd1E      = r_ex.rd1;
  assign rd2E      = r_ex.rd2;
  assign imm_exE   = r_ex.imm;
  assign pcE       = r_ex.pc;
  assign pc4E      = r_ex.pc4;
  assign illegalE  = r_ex.illegal;

endmodule
